// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/multiply-divide block: function codes and FSM states.
package alu_pkg;

   // Function codes carried on the Signal input
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnOr    = 6'b100101;
   localparam logic [5:0] FnAdd   = 6'b100000;
   localparam logic [5:0] FnSub   = 6'b100010;
   localparam logic [5:0] FnSlt   = 6'b101010;
   localparam logic [5:0] FnMultu = 6'b011001;
   localparam logic [5:0] FnMfhi  = 6'b010000;
   localparam logic [5:0] FnMflo  = 6'b010010;

   typedef enum logic {
      StIdle,
      StMul
   } state_e;

   // True for codes whose B operand is inverted with carry-in set
   function automatic logic is_sub_op(input logic [5:0] op);
      return (op == FnSub) || (op == FnSlt);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: AND, OR, ADD, SUB and signed SLT.
// Codes this core does not handle produce result 0 and overflow 0.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [5:0]       i_op,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_add_ovf;

   assign w_is_sub  = is_sub_op(i_op);
   assign w_b_eff   = w_is_sub ? ~i_b : i_b;
   // One adder serves ADD, SUB and SLT; subtraction is A + ~B + 1
   assign w_sum     = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_is_sub};
   assign w_add_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

   // Select the result for the requested function
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (i_op)
         FnAnd: result = i_a & i_b;
         FnOr:  result = i_a | i_b;
         FnAdd, FnSub: begin
            result   = w_sum;
            overflow = w_add_ovf;
         end
         // Sign of the true difference is the raw sign corrected by overflow
         FnSlt: result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_mdu.sv
// ALU with a sequential unsigned multiplier and HI/LO product registers.
// Single-cycle ops complete one edge after acceptance; MULTU takes WIDTH
// shift-add steps and then reports the low product half.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             valid_in,
   output logic             ready,
   output logic [WIDTH-1:0] dataOut,
   output logic             valid_out,
   output logic             zero,
   output logic             overflow
);

   state_e           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic             r_ovf;
   logic             r_valid;

   logic [WIDTH-1:0] w_core_result;
   logic             w_core_ovf;
   logic [WIDTH-1:0] w_op_result;
   logic [WIDTH:0]   w_step_sum;
   logic [WIDTH-1:0] w_hi_next;
   logic [WIDTH-1:0] w_lo_next;
   logic             w_last_step;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_alu_core (
      .i_a      (dataA),
      .i_b      (dataB),
      .i_op     (Signal),
      .result   (w_core_result),
      .overflow (w_core_ovf)
   );

   // HI/LO moves bypass the core; everything else comes from it
   always_comb begin
      w_op_result = w_core_result;
      case (Signal)
         FnMfhi:  w_op_result = r_hi;
         FnMflo:  w_op_result = r_lo;
         default: ;
      endcase
   end

   // Right-shifting product: add the multiplicand into HI when the current
   // multiplier bit is set, then shift {carry, HI, LO} right by one
   assign w_step_sum  = {1'b0, r_hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
   assign w_hi_next   = w_step_sum[WIDTH:1];
   assign w_lo_next   = {w_step_sum[0], r_lo[WIDTH-1:1]};
   assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

   assign ready     = (r_state == StIdle);
   assign dataOut   = r_data;
   assign valid_out = r_valid;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

   // Control FSM, multiplier datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (valid_in) begin
                  if (Signal == FnMultu) begin
                     r_mcand  <= dataA;
                     r_mplier <= dataB;
                     r_hi     <= '0;
                     r_lo     <= '0;
                     r_cnt    <= '0;
                     r_state  <= StMul;
                  end else begin
                     r_data  <= w_op_result;
                     r_zero  <= (w_op_result == '0);
                     r_ovf   <= w_core_ovf;
                     r_valid <= 1'b1;
                  end
               end
            end
            StMul: begin
               r_hi     <= w_hi_next;
               r_lo     <= w_lo_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last_step) begin
                  r_state <= StIdle;
                  r_data  <= w_lo_next;
                  r_zero  <= (w_lo_next == '0);
                  r_ovf   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), multiply-step counter width.
REQ-003 clk  input  1  rising-edge clock; the block's one and only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dataA  input  WIDTH  operand A.
REQ-006 dataB  input  WIDTH  operand B.
REQ-007 Signal  input  6  function code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, MULTU 011001, MFHI 010000, MFLO 010010.
REQ-008 valid_in  input  1  operation request; accepted when valid_in&ready.
REQ-009 ready  output  1  block can accept an operation this cycle.
REQ-010 dataOut  output  WIDTH  registered result.
REQ-011 valid_out  output  1  one-cycle pulse; dataOut/flags valid.
REQ-012 zero  output  1  dataOut==0, registered with dataOut.
REQ-013 overflow  output  1  signed overflow of ADD/SUB; 0 for other codes.

Function
REQ-014 FSM states SHALL be IDLE and MUL; ready=1 only in IDLE.
REQ-015 In IDLE, accepted AND/OR/ADD/SUB/SLT SHALL load dataOut and pulse valid_out on the next rising edge (latency 1).
REQ-016 ADD/SUB SHALL be modulo 2^WIDTH; SUB computes A+~B+1; overflow = operand signs equal (after B inversion) and result sign differs.
REQ-017 SLT SHALL be signed: dataOut = {WIDTH-1 zeros, diff_msb XOR sub_overflow}; overflow output 0.
REQ-018 MFHI/MFLO SHALL return HI/LO with latency 1, overflow 0.
REQ-019 Unknown Signal codes SHALL be accepted, return dataOut=0, zero=1, overflow=0, valid_out pulse.
REQ-020 Accepted MULTU SHALL latch A, B, clear {HI,LO}, set counter=0, enter MUL.
REQ-021 MUL SHALL perform one unsigned shift-add step per cycle; after exactly WIDTH steps {HI,LO} = A*B (2*WIDTH bits, unsigned).
REQ-022 On the cycle the final step registers, FSM SHALL return to IDLE and pulse valid_out with dataOut=LO product bits; total latency WIDTH cycles from acceptance.
REQ-023 valid_in while ready=0 SHALL be ignored with no state change; requester must hold or reissue.
REQ-024 Non-MULTU operations SHALL NOT modify HI/LO.
REQ-025 dataOut, zero and overflow SHALL hold their last value between valid_out pulses.
REQ-026 valid_out SHALL never be asserted two consecutive cycles for the same operation; back-to-back single-cycle ops SHALL produce back-to-back pulses.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ready=1, dataOut=0, zero=1, overflow=0, valid_out=0, HI=LO=0, counter=0.
REQ-028 Reset during MUL SHALL abort the multiply; no valid_out pulse for it after release.
REQ-029 First acceptance SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-030 Function-code constants and the FSM state enum SHALL live in shared package alu_pkg.
REQ-031 Combinational AND/OR/ADD/SUB/SLT logic SHALL be sub-module alu_core (parameter WIDTH; outputs result, overflow); alu_mdu owns FSM, HI/LO and registers.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+0x00000001 -> next cycle dataOut=0x80000000, overflow=1, zero=0, one valid_out pulse.
REQ-033 SUB 5-5 then SLT 0xFFFFFFFF vs 0x00000001 back-to-back -> dataOut 0 (zero=1), then 1; two consecutive pulses.
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> ready low 32 cycles, valid_out with dataOut=0x00000001; MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001.
REQ-035 ADD issued during MULTU busy -> ignored, no extra pulse, HI/LO unchanged; reissued after ready -> correct result.
REQ-036 rst_n low at MUL step 10 -> all outputs reset immediately, no completion pulse, MFHI afterwards returns 0.
REQ-037 Signal=6'b111111, A=B=0x12345678 -> dataOut=0, zero=1, overflow=0, one pulse.
